load_store_unit: RTL
====================

# load_store_unit

Sits between the MEM pipeline stage and `data_memory`, and translates CPU load/store requests into word-wide memory accesses. It supports byte, halfword and word operations, with sign or zero extension on loads. Byte and halfword stores become a read-modify-write sequence, because the data memory only accepts full 32-bit writes. The pipeline is stalled through `req_ready` while a sequence is in flight.

## Interface
- No parameters; data and address widths are fixed at 32 bits.
- `clk`  in  1  system clock; the FSM and all registers update on posedge.
- `Reset`  in  1  asynchronous reset, active-low.
- `req_valid`  in  1  CPU request present; sampled only when `req_ready`=1.
- `req_ready`  out  1  high only in IDLE; low means stall the pipeline.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low byte/half is used for sub-word stores.
- `rsp_valid`  out  1  one-cycle pulse when the operation completes.
- `rsp_rdata`  out  32  extended load result; valid while `rsp_valid`=1, otherwise 0.
- `misalign_exc`  out  1  pulses with `rsp_valid` on a misaligned access.
- `mem_access_addr`  out  32  word address `{addr[31:2],2'b00}`.
- `mem_write_data`  out  32  merged word to write.
- `mem_write_en`  out  1  memory write strobe.
- `mem_read`  out  1  memory read enable.
- `mem_read_data`  in  32  combinational read data from memory.

## Operation
- The request is latched into internal registers (op, addr, wdata) on the posedge where `req_valid && req_ready`.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE -> READ for loads and for sub-word stores.
  - IDLE -> WRITE for word stores.
  - IDLE -> DONE for misaligned requests (when trapping is enabled).
  - READ -> DONE for loads.
  - READ -> WRITE for sub-word stores.
  - WRITE -> DONE.
  - DONE -> IDLE, unconditionally.
- Memory-side outputs are decoded from the registered state only:
  - `mem_read`=1 only in READ.
  - `mem_write_en`=1 only in WRITE.
  - `mem_access_addr` is driven from the latched address in READ and WRITE, and is 0 otherwise.
- Byte lanes are little-endian:
  - byte k occupies bits [8k+7:8k], with k = addr[1:0];
  - a half occupies [15:0] when addr[1]=0, and [31:16] when addr[1]=1.
- Loads:
  - the selected lane of `mem_read_data` is captured at the end of READ;
  - it is then extended per `req_unsigned`;
  - the word result is passed through unchanged.
- Sub-word stores:
  - the word read in READ is captured into a merge register;
  - the selected lane is replaced by `req_wdata[7:0]` or `req_wdata[15:0]`;
  - the merged word is written in WRITE.
- Word store: `mem_write_data` = latched `req_wdata`.
- All outputs reset to 0, except `req_ready`, which resets to 1 (IDLE).
- Reset mid-operation:
  - the FSM returns to IDLE immediately and asynchronously;
  - `mem_write_en` drops at once, so no memory write occurs for the aborted request;
  - no `rsp_valid` is issued for it.

## Timing
- Back-to-back requests are not possible: `req_ready` is low from the accept edge until the edge that re-enters IDLE.
- Latency is counted from the accept edge to the `rsp_valid` cycle:

| Operation | Cycles | Path |
|---|---|---|
| Load | 2 | READ, DONE |
| Word store | 2 | WRITE, DONE |
| Sub-word store | 3 | READ, WRITE, DONE |
| Misaligned (trap on) | 1 | DONE, with no memory access |

- The memory write commits on the negedge inside the WRITE cycle. Read data is combinational and is sampled on the posedge that ends READ.
- A request presented when `req_ready`=0 is ignored. The CPU holds it until `req_ready`=1.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - half accesses with addr[0]=1, or word accesses with addr[1:0]≠0, set `misalign_exc`=1 together with `rsp_valid`;
  - no memory access is made, and `rsp_rdata`=0.
- Undefined:
  - the address is force-aligned instead: addr[0] is cleared for halves, and addr[1:0] is cleared for words;
  - the operation proceeds normally;
  - `misalign_exc` is tied to 0.

## Test plan
- **Reset:** hold `Reset`=0 -> all outputs 0, `req_ready`=1. Release -> state unchanged.
- **Word round-trip:** SW 0xDEADBEEF @0x10, then LW @0x10 -> one write strobe with data 0xDEADBEEF, then `rsp_rdata`=0xDEADBEEF two cycles after the LW accept.
- **Byte merge and extension:** memory word @0x20 = 0x11223344. SB 0xAA @0x22 -> memory becomes 0x11AA3344 after 3 cycles. LB @0x22 -> 0xFFFFFFAA. LBU @0x22 -> 0x000000AA.
- **Halfword:** LH @0x20 on word 0x8001_7FFF -> 0x00007FFF. LH @0x22 -> 0xFFFF8001. SH 0xBEEF @0x22 -> 0xBEEF7FFF.
- **Misaligned LW @0x13:**
  - with `LSU_MISALIGN_TRAP_EN`: `misalign_exc`=1 one cycle after accept, and `mem_read` never high;
  - without it: reads word @0x10.
- **Abort:** assert `Reset`=0 during the READ cycle of an SB -> no `mem_write_en` pulse, memory unchanged, and after release `req_ready`=1 with no `rsp_valid`.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store sequencer with read-modify-write for sub-word stores.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning them.
module load_store_unit (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misalign_exc,
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic accept, mis, op_we, op_uns, exc_q, is_byte, is_half;
  logic [1:0] op_size;
  logic [4:0] sh;
  logic [7:0] byte_l;
  logic [15:0] half_l;
  logic [31:0] addr_in, addr_q, wdata_q, word_q, mask, merged, ext;
  assign accept = req_valid && req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
  assign addr_in = req_addr;
`else
  assign mis = 1'b0;
  assign addr_in = req_size == 2'b01 ? {req_addr[31:1], 1'b0} :
                   req_size[1] ? {req_addr[31:2], 2'b00} : req_addr;
`endif
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = !accept ? IDLE : mis ? DONE : (req_we && req_size[1]) ? WRITE : READ;
      READ:  state_nx = op_we ? WRITE : DONE;
      WRITE: state_nx = DONE;
      DONE:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      op_we   <= 1'b0;
      op_uns  <= 1'b0;
      op_size <= 2'b00;
      exc_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_we   <= req_we;
        op_uns  <= req_unsigned;
        op_size <= req_size;
        exc_q   <= mis;
        addr_q  <= addr_in;
        wdata_q <= req_wdata;
      end
      if (state == READ) word_q <= mem_read_data;
    end
  end
  // Lane position: byte k at bit 8k; halves are already aligned so sh is 0 or 16.
  assign is_byte = op_size == 2'b00;
  assign is_half = op_size == 2'b01;
  assign sh      = {addr_q[1:0], 3'b000};
  assign byte_l  = word_q[sh +: 8];
  assign half_l  = addr_q[1] ? word_q[31:16] : word_q[15:0];
  assign mask    = is_byte ? 32'h0000_00FF << sh : 32'h0000_FFFF << sh;
  assign merged  = (word_q & ~mask) | ((wdata_q << sh) & mask);
  assign ext     = is_byte ? {{24{byte_l[7] & ~op_uns}}, byte_l} :
                   is_half ? {{16{half_l[15] & ~op_uns}}, half_l} : word_q;
  assign req_ready       = state == IDLE;
  assign mem_read        = state == READ;
  assign mem_write_en    = state == WRITE;
  assign rsp_valid       = state == DONE;
  assign misalign_exc    = rsp_valid && exc_q;
  assign mem_access_addr = (mem_read || mem_write_en) ? {addr_q[31:2], 2'b00} : '0;
  assign mem_write_data  = mem_write_en ? ((is_byte || is_half) ? merged : wdata_q) : '0;
  assign rsp_rdata       = (rsp_valid && !op_we && !exc_q) ? ext : '0;
endmodule
